// File: rtl/aes_cipher_core.sv
// rtl/aes_cipher_core.sv - iterative AES-128 encryption core, one round per clock
// Consumes an externally expanded 11-round-key schedule and encrypts one block in 11 edges.
module aes_cipher_core (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [127:0]  plaintext,
  input  logic [1407:0] round_keys,
  input  logic          key_ready,
  output logic          busy,
  output logic          done,
  output logic [127:0]  ciphertext
);
  typedef enum logic [1:0] {IDLE, RUN, FINISH} fsm_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  fsm_t         fsm, fsm_nxt;
  logic [3:0]   round;
  logic [127:0] state_reg;
  logic [127:0] sb, sr, mc, rk;

  // Byte i sits at [127-8*i]; row = i%4, column = i/4.
  for (genvar i = 0; i < 16; i++) begin : g_byte
    localparam int R = i % 4;
    localparam int C = i / 4;
    assign sb[127-8*i -: 8] = SBOX[state_reg[127-8*i -: 8]];
    assign sr[127-8*i -: 8] = sb[127-8*(R + 4*((C + R) % 4)) -: 8];
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = sr[127-32*c -: 8];
    assign a1 = sr[119-32*c -: 8];
    assign a2 = sr[111-32*c -: 8];
    assign a3 = sr[103-32*c -: 8];
    assign mc[127-32*c -: 8] = xtime(a0 ^ a1) ^ a1 ^ a2 ^ a3;
    assign mc[119-32*c -: 8] = xtime(a1 ^ a2) ^ a2 ^ a3 ^ a0;
    assign mc[111-32*c -: 8] = xtime(a2 ^ a3) ^ a3 ^ a0 ^ a1;
    assign mc[103-32*c -: 8] = xtime(a3 ^ a0) ^ a0 ^ a1 ^ a2;
  end

  always_comb begin
    rk = '0;
    for (int i = 1; i <= 10; i++)
      if (round == 4'(i)) rk = round_keys[1407-128*i -: 128];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fsm <= IDLE;
    else      fsm <= fsm_nxt;
  end

  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      IDLE:    if (start && key_ready) fsm_nxt = RUN;
      RUN:     if (round == 4'd10) fsm_nxt = FINISH;
      FINISH:  fsm_nxt = IDLE;
      default: fsm_nxt = IDLE;
    endcase
  end

  // Busy/done are registered so nothing on the inputs reaches them combinationally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      round      <= '0;
      state_reg  <= '0;
      ciphertext <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (fsm)
        IDLE: if (start && key_ready) begin
          state_reg <= plaintext ^ round_keys[1407 -: 128];
          round     <= 4'd1;
          busy      <= 1'b1;
        end
        RUN: begin
          if (round == 4'd10) state_reg <= sr ^ rk;
          else begin
            state_reg <= mc ^ rk;
            round     <= round + 4'd1;
          end
        end
        FINISH: begin
          ciphertext <= state_reg;
          done       <= 1'b1;
          busy       <= 1'b0;
          round      <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule
